argon_mem_responder: RTL

//   Responder end of the Argon core memory port: accepts one word/half/byte access per request, serves
//   it from an internal word array and returns read data with a one-cycle response strobe.

---
 rtl/argon_mem_pkg.sv | 46 ++++
 rtl/argon_mem_array.sv | 20 ++
 rtl/argon_mem_responder.sv | 89 ++++++++
 3 files changed

// File: rtl/argon_mem_pkg.sv
// argon_mem_pkg: mask encodings, responder states and lane helpers shared with the Argon core.
package argon_mem_pkg;
   localparam logic [2:0] RDMASK_NONE = 3'd0;
   localparam logic [2:0] RDMASK_B    = 3'd1;
   localparam logic [2:0] RDMASK_BU   = 3'd2;
   localparam logic [2:0] RDMASK_H    = 3'd3;
   localparam logic [2:0] RDMASK_HU   = 3'd4;
   localparam logic [2:0] RDMASK_W    = 3'd5;
   localparam logic [1:0] WRMASK_NONE = 2'd0;
   localparam logic [1:0] WRMASK_B    = 2'd1;
   localparam logic [1:0] WRMASK_H    = 2'd2;
   localparam logic [1:0] WRMASK_W    = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

   function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] off,
                                                input logic [2:0] rm);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      return rm == RDMASK_B  ? {{24{b[7]}}, b} :
             rm == RDMASK_BU ? {24'b0, b} :
             rm == RDMASK_H  ? {{16{h[15]}}, h} :
             rm == RDMASK_HU ? {16'b0, h} : w;
   endfunction

   function automatic logic [3:0] wr_be(input logic [1:0] wm, input logic [1:0] off);
      return wm == WRMASK_B ? 4'b0001 << off :
             wm == WRMASK_H ? (off[1] ? 4'b1100 : 4'b0011) :
             wm == WRMASK_W ? 4'b1111 : 4'b0000;
   endfunction

   // Replicate store data across lanes so the byte enables alone pick the destination.
   function automatic logic [31:0] wr_lanes(input logic [1:0] wm, input logic [31:0] d);
      return wm == WRMASK_B ? {4{d[7:0]}} : wm == WRMASK_H ? {2{d[15:0]}} : d;
   endfunction

   function automatic logic misaligned(input logic [2:0] rm, input logic [1:0] wm,
                                       input logic [1:0] off);
      logic half, word;
      half = wm == WRMASK_H || (wm == WRMASK_NONE && (rm == RDMASK_H || rm == RDMASK_HU));
      word = wm == WRMASK_W || (wm == WRMASK_NONE && rm == RDMASK_W);
      return (half && off[0]) || (word && off != 2'b00);
   endfunction
endpackage

// File: rtl/argon_mem_array.sv
// argon_mem_array: single-port synchronous word RAM with byte-enable write and registered read.
module argon_mem_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          i_clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge i_clk) begin
      for (int i = 0; i < 4; i++)
         if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      rdata <= mem[addr];
   end
endmodule

// File: rtl/argon_mem_responder.sv
// argon_mem_responder: Argon core memory port target serving word/half/byte accesses from argon_mem_array.
// Define ARGON_MEM_ALIGN_CHECK_EN to fault misaligned half/word accesses instead of ignoring low bits.
module argon_mem_responder
   import argon_mem_pkg::*;
#(
   parameter int DEPTH_WORDS  = 1024,
   parameter int READ_LATENCY = 2
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wr_data,
   input  logic [2:0]  i_rd_mask,
   input  logic [1:0]  i_wr_mask,
   output logic [31:0] o_rd_data,
   output logic        o_rsp_valid,
   output logic        o_fault
);
   localparam int AW = $clog2(DEPTH_WORDS);

   state_t        state, state_nx;
   logic [31:0]   addr_q, wdata_q, ram_rdata;
   logic [2:0]    rd_q;
   logic [1:0]    wr_q;
   logic [3:0]    cnt;
   logic          accept, in_range, bad;
   logic [AW-1:0] ram_addr;

   assign o_req_ready = state == S_IDLE;
   assign o_rsp_valid = state == S_RESP;
   assign accept      = i_req_valid && o_req_ready;
   assign in_range    = addr_q < 32'(DEPTH_WORDS * 4);

`ifdef ARGON_MEM_ALIGN_CHECK_EN
   assign bad     = misaligned(rd_q, wr_q, addr_q[1:0]);
   assign o_fault = o_rsp_valid && bad;
`else
   assign bad     = 1'b0;
   assign o_fault = 1'b0;
`endif

   // Read is launched from the live address at accept so READ_LATENCY=1 still sees registered data.
   assign ram_addr = o_req_ready ? i_addr[AW+1:2] : addr_q[AW+1:2];

   argon_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
      .i_clk (i_clk),
      .we    (state == S_WRITE && i_reset_n && in_range && !bad),
      .be    (wr_be(wr_q, addr_q[1:0])),
      .addr  (ram_addr),
      .wdata (wr_lanes(wr_q, wdata_q)),
      .rdata (ram_rdata)
   );

   always_ff @(posedge i_clk) begin
      if (accept) begin
         addr_q  <= i_addr;
         wdata_q <= i_wr_data;
         rd_q    <= i_rd_mask;
         wr_q    <= i_wr_mask;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         o_rd_data <= 32'd0;
      end else begin
         state <= state_nx;
         if (accept) cnt <= 4'(READ_LATENCY - 1);
         else if (state == S_READ && cnt != 4'd0) cnt <= cnt - 4'd1;
         if (state == S_READ && cnt == 4'd0 && !bad)
            o_rd_data <= in_range ? lane_extract(ram_rdata, addr_q[1:0], rd_q) : 32'd0;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept) state_nx = i_wr_mask != WRMASK_NONE ? S_WRITE :
                                        (i_rd_mask inside {[RDMASK_B:RDMASK_W]}) ? S_READ : S_RESP;
         S_WRITE: state_nx = S_RESP;
         S_READ:  state_nx = cnt == 4'd0 ? S_RESP : S_READ;
         default: state_nx = S_IDLE;
      endcase
   end
endmodule
